// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives an imem request/ack
// interface and presents fetched words through an IF/ID register with stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HELD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, fetch_addr, held_instr, held_pc4;
  logic        redirect, accept;
  logic [31:0] target, fetch_pc4;

  assign redirect  = jump | branch_taken;
  assign target    = jump ? jump_target : branch_target;
  assign accept    = !if_valid | !stall;
  assign fetch_pc4 = fetch_addr + 32'd4;
  assign imem_addr = fetch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (!redirect && !accept) state_nxt = HELD;
        end else if (redirect) begin
          state_nxt = DISCARD;
        end
      end
      HELD:    if (redirect || accept) state_nxt = FETCH;
      DISCARD: if (imem_ack) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH) || (state == DISCARD);
  end

  // A redirect clears if_valid and always beats a simultaneous IF/ID load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      if_instr   <= '0;
      if_pc4     <= '0;
      if_valid   <= 1'b0;
      held_instr <= '0;
      held_pc4   <= '0;
    end else begin
      if ((if_valid && !stall) || redirect) if_valid <= 1'b0;
      case (state)
        IDLE: begin
          pc         <= redirect ? target : pc;
          fetch_addr <= redirect ? target : pc;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pc         <= target;
              fetch_addr <= target;
            end else if (accept) begin
              if_instr   <= imem_rdata;
              if_pc4     <= fetch_pc4;
              if_valid   <= 1'b1;
              pc         <= fetch_pc4;
              fetch_addr <= fetch_pc4;
            end else begin
              held_instr <= imem_rdata;
              held_pc4   <= fetch_pc4;
              pc         <= fetch_pc4;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end
        HELD: begin
          if (redirect) begin
            pc         <= target;
            fetch_addr <= target;
          end else if (accept) begin
            if_instr   <= held_instr;
            if_pc4     <= held_pc4;
            if_valid   <= 1'b1;
            fetch_addr <= pc;
          end
        end
        DISCARD: begin
          // Outstanding request keeps its address; only the return point moves.
          if (imem_ack) begin
            pc         <= redirect ? target : pc;
            fetch_addr <= redirect ? target : pc;
          end else if (redirect) begin
            pc <= target;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential flow, wait states, stall/held,
// redirect during an outstanding request, jump priority, reset and wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the requested address.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    #2;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc4",   if_pc4, 32'h0);

    // sequential fetch, ack tied high
    tick(); tick(); rst = 1'b0;
    check("c1_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("c2_req",  {31'd0, imem_req}, 32'd1);
    check("c2_addr", imem_addr, 32'h0);
    tick();
    check("c3_valid", {31'd0, if_valid}, 32'd1);
    check("c3_instr", if_instr, 32'hA5A5_0000);
    check("c3_pc4",   if_pc4, 32'h4);
    check("c3_addr",  imem_addr, 32'h4);
    tick();
    check("c4_addr", imem_addr, 32'h8);
    check("c4_pc4",  if_pc4, 32'h8);

    // three wait states on the request at 0x8
    imem_ack = 1'b0;
    tick();
    check("ws1_addr",  imem_addr, 32'h8);
    check("ws1_valid", {31'd0, if_valid}, 32'd0);
    tick();
    check("ws2_addr", imem_addr, 32'h8);
    tick();
    check("ws3_addr",  imem_addr, 32'h8);
    check("ws3_valid", {31'd0, if_valid}, 32'd0);
    imem_ack = 1'b1;
    tick();
    check("ws_valid", {31'd0, if_valid}, 32'd1);
    check("ws_pc4",   if_pc4, 32'hC);
    check("ws_addr",  imem_addr, 32'hC);

    // stall while the word for 0x10 returns
    tick();
    check("st0_pc4",  if_pc4, 32'h10);
    check("st0_addr", imem_addr, 32'h10);
    stall = 1'b1;
    tick();
    check("held_req",   {31'd0, imem_req}, 32'd0);
    check("held_valid", {31'd0, if_valid}, 32'd1);
    check("held_pc4",   if_pc4, 32'h10);
    check("held_instr", if_instr, 32'hA5A5_000C);
    tick();
    check("held2_req", {31'd0, imem_req}, 32'd0);
    check("held2_pc4", if_pc4, 32'h10);
    stall = 1'b0;
    tick();
    check("rel_pc4",   if_pc4, 32'h14);
    check("rel_instr", if_instr, 32'hA5A5_0010);
    check("rel_req",   {31'd0, imem_req}, 32'd1);
    check("rel_addr",  imem_addr, 32'h14);

    // branch while the request for 0x20 is outstanding
    tick(); tick(); tick();
    check("pre_br_addr", imem_addr, 32'h20);
    imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    check("disc_req",   {31'd0, imem_req}, 32'd1);
    check("disc_addr",  imem_addr, 32'h20);
    check("disc_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0; imem_ack = 1'b1;
    tick();
    check("disc_drop", {31'd0, if_valid}, 32'd0);
    check("br_addr",   imem_addr, 32'h40);
    tick();
    check("br_valid", {31'd0, if_valid}, 32'd1);
    check("br_pc4",   if_pc4, 32'h44);
    check("br_instr", if_instr, 32'hA5A5_0040);

    // jump beats branch in the same cycle
    jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    jump = 1'b0; branch_taken = 1'b0;
    check("jb_valid", {31'd0, if_valid}, 32'd0);
    check("jb_addr",  imem_addr, 32'h100);
    tick();
    check("jb_pc4", if_pc4, 32'h104);

    // reset asserted while HELD
    stall = 1'b1;
    tick();
    check("h2_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check("mr_valid", {31'd0, if_valid}, 32'd0);
    check("mr_instr", if_instr, 32'h0);
    check("mr_pc4",   if_pc4, 32'h0);
    check("mr_req",   {31'd0, imem_req}, 32'd0);
    check("mr_addr",  imem_addr, 32'h0);
    stall = 1'b0;
    tick(); rst = 1'b0;
    check("rr1_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("rr2_addr", imem_addr, 32'h0);
    check("rr2_req",  {31'd0, imem_req}, 32'd1);
    tick();
    check("rr3_pc4", if_pc4, 32'h4);

    // address wrap at the top of the space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_pc4",   if_pc4, 32'h0);
    check("wr_instr", if_instr, 32'h5A5A_FFFC);
    check("wr_next",  imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
